// File: rtl/regctl_pkg.sv
// Shared constants, FSM state type and opcode classification helpers for the
// register-file port controller.
package regctl_pkg;

    localparam logic [3:0]  OP_LD       = 4'b1101;
    localparam logic [3:0]  OP_LDI      = 4'b1111;
    localparam logic [3:0]  OP_RD_MIN   = 4'd1;
    localparam logic [3:0]  OP_RD_A_MAX = 4'd7;
    localparam logic [3:0]  OP_RD_B_MAX = 4'd3;
    localparam logic [15:0] NOP         = 16'h0000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } regctl_state_e;

    function automatic logic is_writer(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_LDI);
    endfunction

    function automatic logic reads_ra(input logic [3:0] op);
        return (op >= OP_RD_MIN) && (op <= OP_RD_A_MAX);
    endfunction

    function automatic logic reads_rb(input logic [3:0] op);
        return (op >= OP_RD_MIN) && (op <= OP_RD_B_MAX);
    endfunction

endpackage

// File: rtl/regctl_scoreboard.sv
// Shift chain of in-flight register writes; the last slot is the retiring write
// and the union of valid destinations forms the pending-register mask.
module regctl_scoreboard
    import regctl_pkg::*;
#(
    parameter int WB_DEPTH = 3
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_push_valid,
    input  logic [15:0] i_push_opcode,
    output logic        o_retire_valid,
    output logic [15:0] o_retire_opcode,
    output logic [3:0]  o_pending_mask,
    output logic        o_busy
);

    logic        r_valid  [WB_DEPTH];
    logic [15:0] r_opcode [WB_DEPTH];
    logic [3:0]  w_slot_mask [WB_DEPTH];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < WB_DEPTH; i++) begin
                r_valid[i]  <= 1'b0;
                r_opcode[i] <= NOP;
            end
        end else begin
            r_valid[0]  <= i_push_valid;
            r_opcode[0] <= i_push_opcode;
            for (int i = 1; i < WB_DEPTH; i++) begin
                r_valid[i]  <= r_valid[i-1];
                r_opcode[i] <= r_opcode[i-1];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WB_DEPTH; gi++) begin : g_slot_mask
            assign w_slot_mask[gi] = r_valid[gi] ? (4'b0001 << r_opcode[gi][11:10]) : 4'b0000;
        end
    endgenerate

    always_comb begin
        o_pending_mask = 4'b0000;
        o_busy         = 1'b0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            o_pending_mask = o_pending_mask | w_slot_mask[i];
            o_busy         = o_busy | r_valid[i];
        end
    end

    assign o_retire_valid  = r_valid[WB_DEPTH-1];
    assign o_retire_opcode = r_opcode[WB_DEPTH-1];

endmodule

// File: rtl/regfile_port_ctrl.sv
// Arbitrates the register file's single opcode/write-enable port between operand
// reads and delayed load write-back. Optional stall counter under REGCTL_PERF_EN.
module regfile_port_ctrl
    import regctl_pkg::*;
#(
    parameter int WB_DEPTH = 3
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_instr_valid,
    input  logic [15:0] i_instr,
    output logic        o_instr_ready,
    input  logic        i_drain_req,
    output logic [15:0] o_rf_opcode,
    output logic        o_rf_we,
    output logic        o_rf_data_sel,
    output logic        o_busy,
    output logic        o_halted
`ifdef REGCTL_PERF_EN
    ,
    output logic [15:0] o_stall_cnt
`endif
);

    logic          w_retire_valid;
    logic [15:0]   w_retire_opcode;
    logic [3:0]    w_pending_mask;
    logic          w_busy;
    logic          w_hazard;
    logic          w_accept;
    logic          w_push;
    logic [3:0]    w_op;

    regctl_state_e r_state;
    logic [15:0]   r_rf_opcode;
    logic          r_rf_we;
    logic          r_rf_data_sel;

    assign w_op = i_instr[15:12];

    regctl_scoreboard #(.WB_DEPTH(WB_DEPTH)) u_scoreboard (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_push_valid    (w_push),
        .i_push_opcode   (i_instr),
        .o_retire_valid  (w_retire_valid),
        .o_retire_opcode (w_retire_opcode),
        .o_pending_mask  (w_pending_mask),
        .o_busy          (w_busy)
    );

    // WAW is deliberately not a hazard: the shift chain keeps writes in order.
    assign w_hazard = (reads_ra(w_op) && w_pending_mask[i_instr[11:10]]) ||
                      (reads_rb(w_op) && w_pending_mask[i_instr[9:8]]);

    assign o_instr_ready = (r_state == ST_RUN) && !w_retire_valid && !w_hazard;
    assign w_accept      = i_instr_valid && o_instr_ready;
    assign w_push        = w_accept && is_writer(w_op);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= ST_RUN;
            r_rf_opcode   <= NOP;
            r_rf_we       <= 1'b0;
            r_rf_data_sel <= 1'b0;
        end else begin
            if (w_retire_valid) begin
                r_rf_opcode   <= w_retire_opcode;
                r_rf_we       <= 1'b1;
                r_rf_data_sel <= (w_retire_opcode[15:12] == OP_LD);
            end else if (w_accept) begin
                r_rf_opcode   <= i_instr;
                r_rf_we       <= 1'b0;
                r_rf_data_sel <= 1'b0;
            end else begin
                r_rf_opcode   <= NOP;
                r_rf_we       <= 1'b0;
                r_rf_data_sel <= 1'b0;
            end

            case (r_state)
                ST_RUN:   if (i_drain_req) r_state <= ST_DRAIN;
                ST_DRAIN: if (!w_busy)     r_state <= ST_HALT;
                ST_HALT:  if (!i_drain_req) r_state <= ST_RUN;
                default:  r_state <= ST_RUN;
            endcase
        end
    end

    assign o_rf_opcode   = r_rf_opcode;
    assign o_rf_we       = r_rf_we;
    assign o_rf_data_sel = r_rf_data_sel;
    assign o_busy        = w_busy;
    assign o_halted      = (r_state == ST_HALT);

`ifdef REGCTL_PERF_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stall_cnt <= 16'h0000;
        end else if ((r_state == ST_RUN) && i_instr_valid && !o_instr_ready &&
                     (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed scenarios plus randomized traffic for regfile_port_ctrl, checked against
// a transaction-level model of in-flight loads and drain/halt behaviour.
`timescale 1ns/1ps
module tb_regfile_port_ctrl;

    localparam int D = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        drain_req;
    logic        instr_ready;
    logic [15:0] rf_opcode;
    logic        rf_we;
    logic        rf_data_sel;
    logic        busy;
    logic        halted;
`ifdef REGCTL_PERF_EN
    logic [15:0] stall_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_port_ctrl #(.WB_DEPTH(D)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_instr_valid (instr_valid),
        .i_instr       (instr),
        .o_instr_ready (instr_ready),
        .i_drain_req   (drain_req),
        .o_rf_opcode   (rf_opcode),
        .o_rf_we       (rf_we),
        .o_rf_data_sel (rf_data_sel),
        .o_busy        (busy),
        .o_halted      (halted)
`ifdef REGCTL_PERF_EN
        ,
        .o_stall_cnt   (stall_cnt)
`endif
    );

    // Model: each in-flight load remembers the edge on which it must retire.
    typedef struct {
        logic [15:0] op;
        int          ret;
    } wr_t;
    typedef enum {M_RUN, M_DRAIN, M_HALT} mstate_t;

    wr_t     inflight[$];
    mstate_t m_state;
    int      edge_n;
    int      m_stall;
    bit      a;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    function automatic bit m_writes(input logic [15:0] x);
        return (x[15:12] == 4'hD) || (x[15:12] == 4'hF);
    endfunction

    function automatic bit m_hazard(input logic [15:0] x);
        int op = int'(x[15:12]);
        bit h  = 1'b0;
        foreach (inflight[i]) begin
            if (op >= 1 && op <= 7 && inflight[i].op[11:10] == x[11:10]) h = 1'b1;
            if (op >= 1 && op <= 3 && inflight[i].op[11:10] == x[9:8])   h = 1'b1;
        end
        return h;
    endfunction

    // One clock edge: drive, check pre-edge outputs, advance model, check registered outputs.
    task automatic step(input bit v, input logic [15:0] x, input bit dr, output bit acc);
        bit          ret_now   = 1'b0;
        logic [15:0] ret_op    = 16'h0000;
        bit          exp_ready;
        bit          exp_busy;
        logic [15:0] exp_op;
        bit          exp_we;
        bit          exp_sel;
        instr_valid = v;
        instr       = x;
        drain_req   = dr;
        #1;
        foreach (inflight[i]) if (inflight[i].ret == edge_n) begin
            ret_now = 1'b1;
            ret_op  = inflight[i].op;
        end
        exp_busy  = (inflight.size() != 0);
        exp_ready = (m_state == M_RUN) && !ret_now && !m_hazard(x);
        chk("instr_ready", {15'd0, instr_ready}, {15'd0, exp_ready});
        chk("busy",        {15'd0, busy},        {15'd0, exp_busy});
        chk("halted",      {15'd0, halted},      {15'd0, m_state == M_HALT});
        acc = v && exp_ready;
        if (m_state == M_RUN && v && !exp_ready && m_stall != 16'hFFFF) m_stall++;
        @(posedge clk);
        if (ret_now) begin
            exp_op  = ret_op;
            exp_we  = 1'b1;
            exp_sel = (ret_op[15:12] == 4'hD);
            void'(inflight.pop_front());
        end else if (acc) begin
            exp_op  = x;
            exp_we  = 1'b0;
            exp_sel = 1'b0;
        end else begin
            exp_op  = 16'h0000;
            exp_we  = 1'b0;
            exp_sel = 1'b0;
        end
        if (acc && m_writes(x)) inflight.push_back('{x, edge_n + D});
        case (m_state)
            M_RUN:   if (dr)        m_state = M_DRAIN;
            M_DRAIN: if (!exp_busy) m_state = M_HALT;
            M_HALT:  if (!dr)       m_state = M_RUN;
            default: m_state = M_RUN;
        endcase
        edge_n++;
        #1;
        chk("rf_opcode",   rf_opcode,              exp_op);
        chk("rf_we",       {15'd0, rf_we},         {15'd0, exp_we});
        chk("rf_data_sel", {15'd0, rf_data_sel},   {15'd0, exp_sel});
`ifdef REGCTL_PERF_EN
        chk("stall_cnt",   stall_cnt,              m_stall[15:0]);
`endif
        @(negedge clk);
    endtask

    // Called at a negedge; pulses reset with no clock edge inside.
    task automatic do_reset();
        instr_valid = 1'b0;
        drain_req   = 1'b0;
        reset       = 1'b1;
        #1;
        reset       = 1'b0;
        inflight.delete();
        m_state = M_RUN;
        m_stall = 0;
        #1;
        chk("rst_rf_we",     {15'd0, rf_we},       16'd0);
        chk("rst_rf_opcode", rf_opcode,            16'h0000);
        chk("rst_data_sel",  {15'd0, rf_data_sel}, 16'd0);
        chk("rst_busy",      {15'd0, busy},        16'd0);
        chk("rst_halted",    {15'd0, halted},      16'd0);
`ifdef REGCTL_PERF_EN
        chk("rst_stall_cnt", stall_cnt,            16'h0000);
`endif
    endtask

    task automatic flush();
        for (int k = 0; k < D + 3; k++) step(1'b0, 16'h0000, 1'b0, a);
    endtask

    function automatic logic [15:0] rand_instr();
        int          r  = int'($urandom_range(0, 9));
        logic [3:0]  op;
        logic [15:0] x;
        if (r <= 2)      op = ($urandom_range(0, 1) != 0) ? 4'hD : 4'hF;
        else if (r <= 7) op = 4'($urandom_range(1, 7));
        else             op = 4'($urandom_range(8, 12));
        x = 16'($urandom);
        x[15:12] = op;
        return x;
    endfunction

    initial begin
        int          e0;
        int          acc_e;
        int          halt_e;
        int          we_cnt;
        logic [15:0] cur;
        bit          have;
        bit          drn;
        bit          v;

        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        drain_req   = 1'b0;
        edge_n      = 0;
        m_state     = M_RUN;
        m_stall     = 0;
        @(negedge clk);
        do_reset();

        // Reset in the middle of a drain with two loads in flight.
        step(1'b1, 16'hF400, 1'b0, a);
        step(1'b1, 16'hF800, 1'b0, a);
        step(1'b0, 16'h0000, 1'b1, a);
        chk("mid_drain_busy", {15'd0, busy}, 16'd1);
        do_reset();
        step(1'b1, 16'h1B00, 1'b0, a);
        chk("post_reset_accept", {15'd0, a}, 16'd1);
        flush();

        // RAW: ADD R1,R2 behind LDI R1 waits for the write-back.
        e0    = edge_n;
        acc_e = -100;
        step(1'b1, 16'hF45A, 1'b0, a);
        chk("ldi_accept", {15'd0, a}, 16'd1);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 16'h1600, 1'b0, a);
            if (a) begin
                acc_e = edge_n - 1;
                break;
            end
        end
        chk("raw_accept_edge", 16'(acc_e - e0), 16'd4);
        chk("raw_issue_op", rf_opcode, 16'h1600);
        flush();

        // Unrelated reader issues immediately behind a load.
        step(1'b1, 16'hF45A, 1'b0, a);
        step(1'b1, 16'h1B00, 1'b0, a);
        chk("indep_accept", {15'd0, a}, 16'd1);
        flush();

        // Back-to-back loads to the same register retire on consecutive edges.
        we_cnt = 0;
        step(1'b1, 16'hD000, 1'b0, a);
        chk("ld1_accept", {15'd0, a}, 16'd1);
        step(1'b1, 16'hD000, 1'b0, a);
        chk("ld2_accept", {15'd0, a}, 16'd1);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 16'h0000, 1'b0, a);
            if (rf_we && rf_data_sel) we_cnt++;
        end
        chk("ld_retire_count", 16'(we_cnt), 16'd2);
        flush();

        // Drain with one load in flight, then release.
        e0     = edge_n;
        halt_e = -100;
        step(1'b1, 16'hD000, 1'b0, a);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 16'h0000, 1'b1, a);
            if (halted) begin
                halt_e = edge_n - 1;
                break;
            end
        end
        chk("halt_edge", 16'(halt_e - e0), 16'(D + 1));
        step(1'b0, 16'h0000, 1'b0, a);
        step(1'b1, 16'h1B00, 1'b0, a);
        chk("resume_accept", {15'd0, a}, 16'd1);
        flush();

        // Randomized traffic; a presented instruction is held until accepted.
        have = 1'b0;
        drn  = 1'b0;
        cur  = 16'h0000;
        for (int k = 0; k < 400; k++) begin
            if (!have) cur = rand_instr();
            v = have || ($urandom_range(0, 3) != 0);
            if (m_state == M_HALT && $urandom_range(0, 3) == 0)      drn = 1'b0;
            else if (m_state == M_RUN && $urandom_range(0, 49) == 0) drn = 1'b1;
            step(v, cur, drn, a);
            have = v && !a;
        end
        flush();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
